// File: rtl/write_back.sv
// rtl/write_back.sv - RV32I write-back stage: load extract, regfile write, forwarding, misalign trap.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module write_back #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_rd_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  fwd_valid_o,
  output logic [4:0]            fwd_rd_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] misalign_addr_o,
  output logic [CNT_WIDTH-1:0]  retire_cnt_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [1:0] off;
  logic       active;
  logic       is_load;
  logic       is_link;
  logic       writes_rf;
  logic       load_ok;
  logic       misaligned;
  logic       we;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_instr_bits;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign f3      = instr_i[14:12];
  assign off     = alu_result_i[1:0];
  assign unused_instr_bits = ^instr_i[DATA_WIDTH-1:15];

  // Reset gates the combinational write so a pending write is dropped while rst_n is low.
  assign active  = rst_n && !flush_i && !stall_i && (instr_i != '0);
  assign is_load = (opcode == OPC_LOAD);
  assign is_link = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  always_comb begin
    writes_rf = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rf = 1'b1;
      default:                      writes_rf = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_data_i[7:0];
    case (off)
      2'd0: byte_sel = mem_data_i[7:0];
      2'd1: byte_sel = mem_data_i[15:8];
      2'd2: byte_sel = mem_data_i[23:16];
      2'd3: byte_sel = mem_data_i[31:24];
      default: byte_sel = mem_data_i[7:0];
    endcase
    half_sel = off[1] ? mem_data_i[31:16] : mem_data_i[15:0];
  end

  always_comb begin
    load_val   = '0;
    load_ok    = 1'b1;
    misaligned = 1'b0;
    case (f3)
      3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_val = {24'h0, byte_sel};
      3'b001: begin
        load_val   = {{16{half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      3'b101: begin
        load_val   = {16'h0, half_sel};
        misaligned = off[0];
      end
      3'b010: begin
        load_val   = mem_data_i;
        misaligned = (off != 2'b00);
      end
      default: load_ok = 1'b0;
    endcase
    misaligned = misaligned && is_load && active;
  end

  assign we = active && writes_rf && (rd != 5'd0) && !misaligned && !(is_load && !load_ok);

  always_comb begin
    wdata = '0;
    if (we) begin
      if (is_load)      wdata = load_val;
      else if (is_link) wdata = pc_plus4_i;
      else              wdata = alu_result_i;
    end
  end

  assign rf_we_o    = we;
  assign rf_rd_o    = we ? rd : 5'd0;
  assign rf_wdata_o = wdata;

  logic                  fwd_valid_q, fwd_valid_d;
  logic [4:0]            fwd_rd_q, fwd_rd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] mis_addr_q, mis_addr_d;

  // Flush kills the forward copy even under stall; rd/data are simply held.
  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
    if (flush_i) begin
      fwd_valid_d = 1'b0;
    end else if (!stall_i) begin
      fwd_valid_d = we;
      fwd_rd_d    = rf_rd_o;
      fwd_data_d  = wdata;
    end
  end

  always_comb begin
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    if (misaligned) begin
      mis_d = 1'b1;
      if (!mis_q) mis_addr_d = alu_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_data_q  <= '0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
    end
  end

  assign fwd_valid_o     = fwd_valid_q;
  assign fwd_rd_o        = fwd_rd_q;
  assign fwd_data_o      = fwd_data_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (active) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;
`else
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - scoreboard bench for write_back (retire count checked when RETIRE_CNT_EN is defined).
module tb_write_back;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] instr_i = '0, alu_result_i = '0, mem_data_i = '0, pc_plus4_i = '0;
  logic        rf_we_o, fwd_valid_o, misalign_o;
  logic [4:0]  rf_rd_o, fwd_rd_o;
  logic [31:0] rf_wdata_o, fwd_data_o, misalign_addr_o;
  logic [CW-1:0] retire_cnt_o;

  write_back #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .instr_i(instr_i), .alu_result_i(alu_result_i), .mem_data_i(mem_data_i),
    .pc_plus4_i(pc_plus4_i), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
    .rf_wdata_o(rf_wdata_o), .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o),
    .fwd_data_o(fwd_data_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } comb_t;

  typedef struct {
    logic        fv;
    logic [4:0]  fr;
    logic [31:0] fd;
    logic        mis;
    logic [31:0] ma;
    logic [CW-1:0] cnt;
  } seq_t;

  comb_t cq[$];
  seq_t  sq[$];

  int errors = 0;
  int checks = 0;

  logic        m_fv, m_mis;
  logic [4:0]  m_fr;
  logic [31:0] m_fd, m_ma;
  logic [CW-1:0] m_cnt;

  localparam logic [6:0] LOAD = 7'b0000011, OP = 7'b0110011, OPI = 7'b0010011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, STORE = 7'b0100011, BR = 7'b1100011,
                         SYS = 7'b1110011;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    logic [16:0] hi;
    hi = 17'($urandom);
    return {hi, f3, rd, op};
  endfunction

  function automatic void model(input logic [31:0] ins, alu, mem, pc, input logic st, fl,
                                output comb_t c, output logic mis, output logic act);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] sh, ld;
    logic        ok, wr;
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    act = !fl && !st && (ins != 32'h0);
    sh  = mem >> (8 * alu[1:0]);
    ok  = 1'b1;
    mis = 1'b0;
    ld  = 32'h0;
    if (f3 == 3'b000)      ld = sh[7] ? (sh | 32'hFFFFFF00) : (sh & 32'hFF);
    else if (f3 == 3'b100) ld = sh & 32'hFF;
    else if (f3 == 3'b001 || f3 == 3'b101) begin
      sh = alu[1] ? (mem >> 16) : (mem & 32'hFFFF);
      ld = (f3 == 3'b001 && sh[15]) ? (sh | 32'hFFFF0000) : (sh & 32'hFFFF);
      mis = alu[0];
    end else if (f3 == 3'b010) begin
      ld  = mem;
      mis = (alu[1:0] != 2'b00);
    end else ok = 1'b0;
    if (op != LOAD) begin
      mis = 1'b0;
      ok  = 1'b1;
    end
    mis = mis && act;
    wr = (op == LOAD) || (op == OP) || (op == OPI) || (op == LUI) ||
         (op == AUIPC) || (op == JAL) || (op == JALR);
    c.we = act && wr && (rd != 5'd0) && !mis && ok;
    c.rd = c.we ? rd : 5'd0;
    if (!c.we)                       c.wd = 32'h0;
    else if (op == LOAD)             c.wd = ld;
    else if (op == JAL || op == JALR) c.wd = pc;
    else                             c.wd = alu;
  endfunction

  task automatic model_reset();
    m_fv = 0; m_fr = 0; m_fd = 0; m_mis = 0; m_ma = 0; m_cnt = 0;
  endtask

  task automatic apply(input logic [31:0] ins, alu, mem, pc, input logic st, fl);
    comb_t c, cg;
    seq_t  s, sg;
    logic  mis, act;
    @(negedge clk);
    instr_i = ins; alu_result_i = alu; mem_data_i = mem; pc_plus4_i = pc;
    stall_i = st; flush_i = fl;
    model(ins, alu, mem, pc, st, fl, c, mis, act);
    cq.push_back(c);
    if (fl) m_fv = 1'b0;
    else if (!st) begin m_fv = c.we; m_fr = c.rd; m_fd = c.wd; end
    if (mis) begin
      if (!m_mis) m_ma = alu;
      m_mis = 1'b1;
    end
`ifdef RETIRE_CNT_EN
    if (act) m_cnt = m_cnt + 1'b1;
`endif
    s.fv = m_fv; s.fr = m_fr; s.fd = m_fd; s.mis = m_mis; s.ma = m_ma; s.cnt = m_cnt;
    sq.push_back(s);
    #1;
    cg = cq.pop_front();
    check("rf_we", 32'(rf_we_o), 32'(cg.we));
    check("rf_rd", 32'(rf_rd_o), 32'(cg.rd));
    check("rf_wdata", rf_wdata_o, cg.wd);
    @(posedge clk);
    #1;
    sg = sq.pop_front();
    check("fwd_valid", 32'(fwd_valid_o), 32'(sg.fv));
    check("fwd_rd", 32'(fwd_rd_o), 32'(sg.fr));
    check("fwd_data", fwd_data_o, sg.fd);
    check("misalign", 32'(misalign_o), 32'(sg.mis));
    check("misalign_addr", misalign_addr_o, sg.ma);
    check("retire_cnt", 32'(retire_cnt_o), 32'(sg.cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_i = mk(OPI, 3'b000, 5'd3); alu_result_i = 32'h77; stall_i = 0; flush_i = 0;
    #1;
    check("rst_rf_we", 32'(rf_we_o), 32'h0);
    check("rst_rf_wdata", rf_wdata_o, 32'h0);
    check("rst_fwd_valid", 32'(fwd_valid_o), 32'h0);
    check("rst_fwd_data", fwd_data_o, 32'h0);
    check("rst_misalign", 32'(misalign_o), 32'h0);
    check("rst_misalign_addr", misalign_addr_o, 32'h0);
    check("rst_retire_cnt", 32'(retire_cnt_o), 32'h0);
    model_reset();
    @(negedge clk);
    instr_i = 32'h0;
    rst_n = 1'b1;
  endtask

  logic [6:0] ops [10] = '{LOAD, OP, OPI, LUI, AUIPC, JAL, JALR, STORE, BR, SYS};

  initial begin
    logic [31:0] exp_cnt;
    model_reset();
    do_reset();

    apply(mk(LOAD, 3'b000, 5'd5), 32'h1002, 32'h80FF1234, 32'h0, 0, 0);
    check("lb_wdata_const", fwd_data_o, 32'hFFFFFFFF);
    apply(mk(LOAD, 3'b100, 5'd5), 32'h1002, 32'h80FF1234, 32'h0, 0, 0);
    check("lbu_wdata_const", fwd_data_o, 32'h000000FF);
    apply(mk(LOAD, 3'b001, 5'd6), 32'h1002, 32'h80017FFF, 32'h0, 0, 0);
    check("lh_wdata_const", fwd_data_o, 32'hFFFF8001);
    apply(mk(LOAD, 3'b101, 5'd6), 32'h1000, 32'h80017FFF, 32'h0, 0, 0);
    apply(mk(LOAD, 3'b000, 5'd8), 32'h1001, 32'h80FF1234, 32'h0, 0, 0);
    apply(mk(LOAD, 3'b000, 5'd8), 32'h1003, 32'h80FF1234, 32'h0, 0, 0);
    apply(mk(LOAD, 3'b010, 5'd8), 32'h1000, 32'hDEADBEEF, 32'h0, 0, 0);
    apply(mk(LOAD, 3'b011, 5'd8), 32'h1000, 32'hDEADBEEF, 32'h0, 0, 0);
    apply(mk(LOAD, 3'b010, 5'd4), 32'h1003, 32'h12345678, 32'h0, 0, 0);
    check("lw_mis_addr_const", misalign_addr_o, 32'h1003);
    apply(mk(LOAD, 3'b001, 5'd4), 32'h2001, 32'h12345678, 32'h0, 0, 0);
    check("mis_addr_held_const", misalign_addr_o, 32'h1003);

    apply(mk(OP, 3'b000, 5'd0), 32'h55, 32'h0, 32'h0, 0, 0);
    apply(mk(OPI, 3'b000, 5'd7), 32'h55, 32'h0, 32'h0, 0, 0);
    apply(mk(JAL, 3'b000, 5'd1), 32'h999, 32'h0, 32'h104, 0, 0);
    apply(mk(JALR, 3'b000, 5'd2), 32'h999, 32'h0, 32'h208, 0, 0);
    apply(mk(LUI, 3'b000, 5'd10), 32'hABC00000, 32'h0, 32'h0, 0, 0);
    apply(mk(AUIPC, 3'b000, 5'd11), 32'h00401000, 32'h0, 32'h0, 0, 0);
    apply(mk(STORE, 3'b010, 5'd12), 32'h1000, 32'h0, 32'h0, 0, 0);
    apply(mk(BR, 3'b000, 5'd12), 32'h1000, 32'h0, 32'h0, 0, 0);
    apply(mk(OPI, 3'b000, 5'd3), 32'h33, 32'h0, 32'h0, 1, 0);
    apply(mk(OPI, 3'b000, 5'd3), 32'h33, 32'h0, 32'h0, 1, 1);
    apply(mk(OPI, 3'b000, 5'd9), 32'hABCD, 32'h0, 32'h0, 0, 0);
    apply(32'h0, 32'h1234, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      ins = mk(ops[$urandom_range(0, 9)], 3'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) ins = 32'h0;
      apply(ins, $urandom, $urandom, $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply(mk(STORE, 3'b010, 5'd1), 32'h100 + i, 32'h0, 32'h0, 0, 0);
      apply(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    end
`ifdef RETIRE_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    check("cnt_wrap", 32'(retire_cnt_o), exp_cnt);
    apply(mk(OP, 3'b000, 5'd2), 32'h5, 32'h0, 32'h0, 0, 0);
    do_reset();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
